// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared state encoding and event priority constants for the vending block
package vm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_VEND   = 2'd2;
  localparam logic [1:0] ST_REFUND = 2'd3;

  // Winning event of a cycle in IDLE/CREDIT, decoded cancel > select > coin
  localparam logic [1:0] EV_NONE   = 2'd0;
  localparam logic [1:0] EV_CANCEL = 2'd1;
  localparam logic [1:0] EV_SEL    = 2'd2;
  localparam logic [1:0] EV_COIN   = 2'd3;

endpackage

// File: rtl/vm_stock_cnt.sv
// rtl/vm_stock_cnt.sv - per-item stock counter with restock load and saturating decrement
module vm_stock_cnt #(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic empty
);

  logic [STOCK_W-1:0] count;

  // A restock in the same cycle as a sale wins, leaving the counter full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= STOCK_W'(STOCK_INIT);
    end else if (load) begin
      count <= STOCK_W'(STOCK_INIT);
    end else if (dec && (count != '0)) begin
      count <= count - STOCK_W'(1);
    end
  end

  assign empty = (count == '0);

endmodule

// File: rtl/vm_multi_item.sv
// rtl/vm_multi_item.sv - multi-product vending controller: credit, select, vend and refund FSM
module vm_multi_item
  import vm_pkg::*;
#(
  parameter int                            NUM_ITEMS  = 2,
  parameter int                            CREDIT_W   = 4,
  parameter int                            MAX_CREDIT = 9,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {4'd3, 4'd1},
  parameter int                            STOCK_W    = 4,
  parameter int                            STOCK_INIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_coin,
  input  logic [CREDIT_W-1:0]  i_coin_val,
  input  logic [NUM_ITEMS-1:0] i_sel,
  input  logic                 i_cancel,
  input  logic [NUM_ITEMS-1:0] i_restock,
  output logic [NUM_ITEMS-1:0] o_led,
  output logic [NUM_ITEMS-1:0] o_dispense,
  output logic                 o_change_vld,
  output logic [CREDIT_W-1:0]  o_change,
  output logic                 o_coin_rej,
  output logic [CREDIT_W-1:0]  o_credit,
  output logic [NUM_ITEMS-1:0] o_empty
);

  logic [1:0]           state;
  logic [CREDIT_W-1:0]  credit;
  logic [CREDIT_W-1:0]  refund_amt;
  logic [NUM_ITEMS-1:0] vend_item;
  logic                 coin_rej;

  logic                 active;
  logic [NUM_ITEMS-1:0] afford;
  logic [NUM_ITEMS-1:0] empty;
  logic [NUM_ITEMS-1:0] dec;
  logic                 sel_onehot;
  logic                 sel_ok;
  logic [CREDIT_W-1:0]  sel_price;
  logic [CREDIT_W:0]    coin_sum;
  logic                 coin_ok;
  logic [1:0]           ev;

  assign active = (state == ST_IDLE) || (state == ST_CREDIT);

  always_comb begin
    afford    = '0;
    sel_price = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      afford[k] = (credit >= PRICES[k*CREDIT_W +: CREDIT_W]) && !empty[k];
      if (i_sel[k]) begin
        sel_price = sel_price | PRICES[k*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign sel_onehot = (i_sel != '0) && ((i_sel & (i_sel - NUM_ITEMS'(1))) == '0);
  assign sel_ok     = active && sel_onehot && ((i_sel & afford) != '0);

  // Extra bit keeps the overflow test exact when credit is near the bus maximum
  assign coin_sum = {1'b0, credit} + {1'b0, i_coin_val};
  assign coin_ok  = (i_coin_val != '0) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    ev = EV_NONE;
    if (active) begin
      if (i_cancel && (state == ST_CREDIT)) begin
        ev = EV_CANCEL;
      end else if (sel_ok) begin
        ev = EV_SEL;
      end else if (i_coin) begin
        ev = EV_COIN;
      end
    end
  end

  assign dec = (ev == EV_SEL) ? i_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      credit     <= '0;
      refund_amt <= '0;
      vend_item  <= '0;
      coin_rej   <= 1'b0;
    end else begin
      // Any coin not banked this cycle is bounced, including ones in VEND/REFUND
      coin_rej <= i_coin && !((ev == EV_COIN) && coin_ok);
      case (state)
        ST_IDLE, ST_CREDIT: begin
          case (ev)
            EV_CANCEL: begin
              state      <= ST_REFUND;
              refund_amt <= credit;
              credit     <= '0;
            end
            EV_SEL: begin
              state     <= ST_VEND;
              credit    <= credit - sel_price;
              vend_item <= i_sel;
            end
            EV_COIN: begin
              if (coin_ok) begin
                credit <= coin_sum[CREDIT_W-1:0];
                state  <= ST_CREDIT;
              end
            end
            default: ;
          endcase
        end
        ST_VEND: begin
          state <= (credit != '0) ? ST_CREDIT : ST_IDLE;
        end
        ST_REFUND: begin
          state      <= ST_IDLE;
          refund_amt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_ITEMS; k++) begin : g_stock
    vm_stock_cnt #(
      .STOCK_W   (STOCK_W),
      .STOCK_INIT(STOCK_INIT)
    ) u_stock (
      .clk  (clk),
      .rst  (rst),
      .load (i_restock[k]),
      .dec  (dec[k]),
      .empty(empty[k])
    );
  end

  assign o_led        = active ? afford : '0;
  assign o_dispense   = (state == ST_VEND) ? vend_item : '0;
  assign o_change_vld = (state == ST_REFUND);
  assign o_change     = o_change_vld ? refund_amt : '0;
  assign o_coin_rej   = coin_rej;
  assign o_credit     = credit;
  assign o_empty      = empty;

endmodule
